// File: rtl/and_result_monitor.sv
// and_result_monitor
// ------------------
// Consumer of the two-output AND stage. Counts, over a window of WINDOW
// accepted samples, how many continuous-assign results were 1 and how many
// samples had the two implementations disagreeing. Each window ends with a
// count report over a valid/ready handshake. A sticky flag records any
// disagreement since reset or clear.
//
// Optional feature macro: AND_MON_MISMATCH_CNT_EN
//   defined   -> per-window mismatch counter built, rpt_mismatch reports it
//   undefined -> mismatch counter omitted, rpt_mismatch tied to 0
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   in_valid       sample present on in_assign/in_alwaysblock
//   in_ready       block accepts a sample (low while a report is pending)
//   in_assign      continuous-assign result from the AND stage
//   in_alwaysblock always-block result from the AND stage
//   clear          synchronous abort of window, report and sticky flag
//   rpt_valid      report is valid
//   rpt_ready      consumer accepts the report
//   rpt_ones       samples in the window with in_assign=1
//   rpt_mismatch   samples in the window with in_assign != in_alwaysblock
//   mismatch_seen  sticky disagreement flag
module and_result_monitor #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_assign,
  input  logic             in_alwaysblock,
  input  logic             clear,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_ones,
  output logic [CNT_W-1:0] rpt_mismatch,
  output logic             mismatch_seen
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
  logic             seen_q, seen_d;
  logic             accept;
  logic             differ;
  logic [CNT_W-1:0] sample_cnt_inc;

`ifdef AND_MON_MISMATCH_CNT_EN
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
`endif

  // Saturating increment; never saturates with legal parameters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  assign accept         = in_valid && in_ready;
  assign differ         = in_assign ^ in_alwaysblock;
  assign sample_cnt_inc = sat_inc(sample_cnt_q, 1'b1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the accept that completes the window goes straight to
  // REPORT, which also covers WINDOW=1 from IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d = (sample_cnt_inc == CNT_W'(WINDOW)) ? REPORT : ACCUM;
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
    end
  end

  // Output logic; the report reads the held window counters directly, since
  // no sample can be accepted while in REPORT.
  always_comb begin
    in_ready     = (state_q != REPORT);
    rpt_valid    = (state_q == REPORT);
    rpt_ones     = rpt_valid ? ones_cnt_q : '0;
`ifdef AND_MON_MISMATCH_CNT_EN
    rpt_mismatch = rpt_valid ? mis_cnt_q : '0;
`else
    rpt_mismatch = '0;
`endif
  end

  assign mismatch_seen = seen_q;

  // Counter datapath: clear beats the report handshake, which beats an accept.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    seen_d       = seen_q;
`ifdef AND_MON_MISMATCH_CNT_EN
    mis_cnt_d    = mis_cnt_q;
`endif
    if (clear) begin
      sample_cnt_d = '0;
      ones_cnt_d   = '0;
      seen_d       = 1'b0;
`ifdef AND_MON_MISMATCH_CNT_EN
      mis_cnt_d    = '0;
`endif
    end else if ((state_q == REPORT) && rpt_ready) begin
      sample_cnt_d = '0;
      ones_cnt_d   = '0;
`ifdef AND_MON_MISMATCH_CNT_EN
      mis_cnt_d    = '0;
`endif
    end else if (accept) begin
      sample_cnt_d = sample_cnt_inc;
      ones_cnt_d   = sat_inc(ones_cnt_q, in_assign);
      seen_d       = seen_q | differ;
`ifdef AND_MON_MISMATCH_CNT_EN
      mis_cnt_d    = sat_inc(mis_cnt_q, differ);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
      seen_q       <= 1'b0;
`ifdef AND_MON_MISMATCH_CNT_EN
      mis_cnt_q    <= '0;
`endif
    end else begin
      sample_cnt_q <= sample_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      seen_q       <= seen_d;
`ifdef AND_MON_MISMATCH_CNT_EN
      mis_cnt_q    <= mis_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_and_result_monitor.sv
// Testbench for and_result_monitor. Two instances share one stimulus stream:
// dut4 (WINDOW=4) and dut1 (WINDOW=1). A window-level model predicts every
// output of both each cycle; literal checks pin the key scenarios.
module tb_and_result_monitor;

`ifdef AND_MON_MISMATCH_CNT_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_assign = 1'b0;
  logic in_alwaysblock = 1'b0;
  logic clear = 1'b0;
  logic rpt_ready = 1'b0;

  logic       rdy4, vld4, seen4;
  logic [7:0] ones4, mis4;
  logic       rdy1, vld1, seen1;
  logic [7:0] ones1, mis1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  and_result_monitor #(.WINDOW(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .in_assign(in_assign), .in_alwaysblock(in_alwaysblock), .clear(clear),
    .rpt_valid(vld4), .rpt_ready(rpt_ready), .rpt_ones(ones4),
    .rpt_mismatch(mis4), .mismatch_seen(seen4)
  );

  and_result_monitor #(.WINDOW(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_assign(in_assign), .in_alwaysblock(in_alwaysblock), .clear(clear),
    .rpt_valid(vld1), .rpt_ready(rpt_ready), .rpt_ones(ones1),
    .rpt_mismatch(mis1), .mismatch_seen(seen1)
  );

  // Window-level model: index 0 -> dut4, index 1 -> dut1.
  int m_win[2] = '{4, 1};
  int m_n[2];
  int m_ones[2];
  int m_mis[2];
  int m_rep_ones[2];
  int m_rep_mis[2];
  bit m_rpt[2];
  bit m_seen[2];

  task automatic model_zero(input int i);
    m_n[i] = 0; m_ones[i] = 0; m_mis[i] = 0;
    m_rep_ones[i] = 0; m_rep_mis[i] = 0;
    m_rpt[i] = 1'b0; m_seen[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    if (clear) begin
      model_zero(i);
    end else if (m_rpt[i]) begin
      if (rpt_ready) begin
        m_rpt[i] = 1'b0;
        m_rep_ones[i] = 0;
        m_rep_mis[i] = 0;
      end
    end else if (in_valid) begin
      m_n[i]++;
      if (in_assign) m_ones[i]++;
      if (in_assign != in_alwaysblock) begin
        m_mis[i]++;
        m_seen[i] = 1'b1;
      end
      if (m_n[i] == m_win[i]) begin
        m_rpt[i] = 1'b1;
        m_rep_ones[i] = m_ones[i];
        m_rep_mis[i] = MIS_EN ? m_mis[i] : 0;
        m_n[i] = 0; m_ones[i] = 0; m_mis[i] = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) model_zero(i);
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_dut(input string tag, input int i, input logic rdy,
                             input logic vld, input logic [7:0] ones,
                             input logic [7:0] mis, input logic seen);
    checkOutput({tag, ".in_ready"}, 32'(rdy), 32'(!m_rpt[i]));
    checkOutput({tag, ".rpt_valid"}, 32'(vld), 32'(m_rpt[i]));
    checkOutput({tag, ".rpt_ones"}, 32'(ones), 32'(m_rpt[i] ? m_rep_ones[i] : 0));
    checkOutput({tag, ".rpt_mismatch"}, 32'(mis), 32'(m_rpt[i] ? m_rep_mis[i] : 0));
    checkOutput({tag, ".mismatch_seen"}, 32'(seen), 32'(m_seen[i]));
  endtask

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    compare_dut("model4", 0, rdy4, vld4, ones4, mis4, seen4);
    compare_dut("model1", 1, rdy1, vld1, ones1, mis1, seen1);
  end

  // Drive inputs for one rising edge; return 2ns after that edge.
  task automatic applyStimulus(input bit v, input bit a, input bit b,
                               input bit rr, input bit clr);
    in_valid = v; in_assign = a; in_alwaysblock = b;
    rpt_ready = rr; clear = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic check4(input string name, input logic rdy, input logic vld,
                        input int ones, input int mis, input logic seen);
    checkOutput({name, ".in_ready"}, 32'(rdy4), 32'(rdy));
    checkOutput({name, ".rpt_valid"}, 32'(vld4), 32'(vld));
    checkOutput({name, ".rpt_ones"}, 32'(ones4), 32'(ones));
    checkOutput({name, ".rpt_mismatch"}, 32'(mis4), 32'(mis));
    checkOutput({name, ".mismatch_seen"}, 32'(seen4), 32'(seen));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check4("rst_during", 1, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #2;
    check4("rst_held", 1, 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    check4("rst_after", 1, 0, 0, 0, 0);

    // Reset mid-ACCUM after two samples
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    check4("pre_rst_seen", 1, 0, 0, 0, 1);
    rst = 1'b1;
    #1 check4("mid_rst", 1, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Four continuous accepts
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    check4("win_not_yet", 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    check4("win_report", 0, 1, 3, MIS_EN ? 1 : 0, 1);

    // Report held while in_valid offers new data
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1, 1, 0, 0);
      check4("hold", 0, 1, 3, MIS_EN ? 1 : 0, 1);
    end
    applyStimulus(1, 0, 0, 1, 0);
    check4("handshake", 1, 0, 0, 0, 1);

    // Clear, then gapped all-zero window
    applyStimulus(0, 0, 0, 0, 1);
    check4("clear_idle", 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    check4("gap_not_yet", 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    check4("gap_report", 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    check4("gap_release", 1, 0, 0, 0, 0);

    // Clear in REPORT coincident with rpt_ready
    for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0, 0, 0);
    check4("pre_clear_rpt", 0, 1, 4, MIS_EN ? 4 : 0, 1);
    applyStimulus(1, 1, 0, 1, 1);
    check4("clear_in_rpt", 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    check4("post_clear_1", 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, 1, 0, 0);
    check4("post_clear_rpt", 0, 1, 4, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);

    // Clear after three samples
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    check4("clear_mid", 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    check4("clear_mid_1", 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 0);
    check4("clear_mid_rpt", 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);

    // WINDOW=1 instance
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("w1.rpt_valid", 32'(vld1), 32'd1);
    checkOutput("w1.in_ready", 32'(rdy1), 32'd0);
    checkOutput("w1.rpt_ones", 32'(ones1), 32'd1);
    checkOutput("w1.rpt_mismatch", 32'(mis1), MIS_EN ? 32'd1 : 32'd0);
    checkOutput("w1.mismatch_seen", 32'(seen1), 32'd1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("w1.release_valid", 32'(vld1), 32'd0);
    checkOutput("w1.release_ones", 32'(ones1), 32'd0);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("w1.second_valid", 32'(vld1), 32'd1);
    checkOutput("w1.second_mis", 32'(mis1), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/and_result_monitor.md
# and_result_monitor

- Downstream consumer of the two-output AND stage. Receives the stage's continuous-assign result and always-block result as a sample stream.
- Over a fixed window of accepted samples, it counts logic-1 results and disagreements between the two results.
- At the end of each window it presents a count report over a valid/ready handshake.
- It keeps a sticky flag if the two implementations ever disagreed.

## Interface
Parameters:
- WINDOW, 16: accepted samples per report; legal range 1..255.
- CNT_W, 8: report counter width; must satisfy 2^CNT_W > WINDOW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a sample is present on in_assign/in_alwaysblock.
- in_ready  out  1  block can accept a sample; 1 in IDLE/ACCUM, 0 in REPORT.
- in_assign  in  1  out_assign result from the upstream AND stage.
- in_alwaysblock  in  1  out_alwaysblock result from the upstream AND stage.
- clear  in  1  synchronous abort: drop the current window and any pending report, and clear the sticky flag.
- rpt_valid  out  1  report is valid.
- rpt_ready  in  1  consumer accepts the report.
- rpt_ones  out  CNT_W  number of samples in the window with in_assign=1.
- rpt_mismatch  out  CNT_W  number of samples in the window with in_assign≠in_alwaysblock.
- mismatch_seen  out  1  sticky flag: any accepted sample since reset/clear disagreed.

## Operation
- A sample is accepted on a rising edge where in_valid && in_ready.
- Per accepted sample:
  - sample_cnt += 1.
  - ones_cnt += in_assign.
  - mis_cnt += (in_assign ^ in_alwaysblock).
  - mismatch_seen is set if the two inputs differ.
- All counters are CNT_W wide, unsigned, and saturate at 2^CNT_W−1. With legal parameters they never reach saturation.
- FSM states:
  - IDLE: sample_cnt=0. An accepted sample moves to ACCUM, or straight to REPORT when WINDOW=1.
  - ACCUM: accepts samples. The accept that makes sample_cnt reach WINDOW moves to REPORT, latching the final counts including that sample into rpt_ones/rpt_mismatch.
  - REPORT: rpt_valid=1, in_ready=0, report outputs held stable. When rpt_valid && rpt_ready, counters zero and the FSM moves to IDLE.
- clear, when high at a rising edge:
  - FSM goes to IDLE; all counters, rpt_* outputs and mismatch_seen are zeroed.
  - Any sample or report handshake in the same cycle is discarded.
  - clear has priority over all events except rst.
- rpt_ones/rpt_mismatch read 0 whenever rpt_valid=0.

## Timing
- Reset values (asynchronous, immediate on rst rising):
  - FSM=IDLE.
  - in_ready=1, rpt_valid=0, rpt_ones=0, rpt_mismatch=0, mismatch_seen=0.
  - All internal counters=0.
- Reset mid-window or mid-report discards all progress. No report is emitted.
- Report latency: rpt_valid rises the cycle after the edge that accepts the WINDOW-th sample.
- in_ready falls in that same cycle, so there is no overlap between the last accept and the report.
- Report handshake:
  - A report may be held indefinitely while rpt_ready=0.
  - The handshake completes on the edge with rpt_valid && rpt_ready.
  - in_ready=1 and rpt_valid=0 from the next cycle.
- Back-to-back throughput is WINDOW accepts plus at least 1 report cycle per window.
- mismatch_seen rises the cycle after the offending accept. It stays high across windows until rst or clear.
- in_valid with in_ready=0 is ignored. The upstream holds its data; no sample is lost or double-counted.

## Configuration
- AND_MON_MISMATCH_CNT_EN defined:
  - The per-window mismatch counter is built.
  - rpt_mismatch reports the count as specified above.
- AND_MON_MISMATCH_CNT_EN undefined:
  - The mismatch counter is omitted.
  - rpt_mismatch is tied to 0.
  - mismatch_seen is still implemented and behaves identically.
  - All other behaviour is unchanged.

## Test plan
- WINDOW=4, rst pulse:
  - All outputs read reset values during and after rst.
  - rst asserted mid-ACCUM (after 2 samples) gives no report, and the next window starts from 0.
- WINDOW=4, macro defined, four continuous accepts (assign,always) = (1,1),(0,0),(1,1),(1,0):
  - The cycle after the 4th accept: rpt_valid=1, rpt_ones=3, rpt_mismatch=1, mismatch_seen=1, in_ready=0.
- Hold rpt_ready=0 for 5 cycles while in_valid=1 with new data:
  - The report stays stable and no samples are accepted.
  - With rpt_ready=1 for one cycle, the next cycle shows rpt_valid=0, in_ready=1, rpt_ones=0.
- Gapped in_valid (accept, 3 idle, accept, accept, 1 idle, accept), all (0,0):
  - The report appears exactly one cycle after the 4th accept, with rpt_ones=0 and rpt_mismatch=0.
  - mismatch_seen stays 0.
- clear in the REPORT state coincident with rpt_ready=1, and separately after 3 samples:
  - The next cycle shows FSM IDLE, rpt_valid=0, mismatch_seen=0.
  - The following window counts only post-clear samples.
- Macro undefined, same stimulus as the second scenario:
  - rpt_ones=3, rpt_mismatch=0, mismatch_seen=1.
- WINDOW=1:
  - Each accept produces a report the next cycle.
  - Single (1,0) gives rpt_ones=1, rpt_mismatch=1.
